// File: rtl/window3x3_gen.sv
`default_nettype none
// ============================================================================
//  Module      : window3x3_gen
//  Description : Turns a raster-order pixel stream into 3x3 sliding windows
//                for a downstream conv3x3. Two line buffers hold the previous
//                two image rows. A two-column shift register holds the last
//                two pixel columns. The registered outputs complete the 3x3
//                window. Only fully valid windows are emitted, with no padding.
//  Ports       : iClk        - clock, rising edge
//                iRsn        - asynchronous active-low reset
//                iSoftClr    - synchronous frame restart (drops current pixel)
//                iInValid    - iInData carries a pixel this cycle
//                iInData     - signed pixel, WI bits, raster order
//                oOutValid   - window outputs valid this cycle
//                oWindowRow1 - top row    {left, middle, right} (row-2)
//                oWindowRow2 - middle row {left, middle, right} (row-1)
//                oWindowRow3 - bottom row {left, middle, right} (row)
//                oFrameDone  - pulse: last pixel of the frame was accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module window3x3_gen #(
  parameter int WI    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iSoftClr,
  input  logic              iInValid,
  input  logic [WI-1:0]     iInData,
  output logic              oOutValid,
  output logic [3*WI-1:0]   oWindowRow1,
  output logic [3*WI-1:0]   oWindowRow2,
  output logic [3*WI-1:0]   oWindowRow3,
  output logic              oFrameDone
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_COL_TWO  = CW'(2);
  localparam logic [RW-1:0] c_ROW_TWO  = RW'(2);

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;

  // Line buffers: r_lb0 holds image row row-2, r_lb1 holds row row-1.
  logic [WI-1:0]        r_lb0 [IMG_W];
  logic [WI-1:0]        r_lb1 [IMG_W];

  // The two most recent window columns. Index [1] is the older column, which
  // becomes the left pixel of the next window.
  logic [1:0][WI-1:0]   r_sr1;
  logic [1:0][WI-1:0]   r_sr2;
  logic [1:0][WI-1:0]   r_sr3;

  logic                 w_accept;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_win_ok;
  logic [WI-1:0]        w_top;
  logic [WI-1:0]        w_mid;
  logic [3*WI-1:0]      w_win1;
  logic [3*WI-1:0]      w_win2;
  logic [3*WI-1:0]      w_win3;

  // The soft clear discards the pixel presented in the same cycle.
  assign w_accept   = iInValid & ~iSoftClr;
  assign w_col_last = (r_col == c_COL_LAST);
  assign w_row_last = (r_row == c_ROW_LAST);

  // col>=2 masks shift-register columns left over from the previous row.
  // row>=2 masks stale line-buffer data from the previous frame or from
  // before reset.
  assign w_win_ok   = (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);

  // Line-buffer reads use the values from before this cycle's write.
  assign w_top  = r_lb0[r_col];
  assign w_mid  = r_lb1[r_col];

  assign w_win1 = {r_sr1, w_top};
  assign w_win2 = {r_sr2, w_mid};
  assign w_win3 = {r_sr3, iInData};

  // Position counters
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (iSoftClr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (iInValid) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Line buffers have no reset. Their contents are masked until two full
  // rows of the current frame have been written.
  always_ff @(posedge iClk) begin
    if (w_accept) begin
      r_lb0[r_col] <= w_mid;
      r_lb1[r_col] <= iInData;
    end
  end

  // Column shift register
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_sr1 <= '0;
      r_sr2 <= '0;
      r_sr3 <= '0;
    end else if (w_accept) begin
      r_sr1 <= {r_sr1[0], w_top};
      r_sr2 <= {r_sr2[0], w_mid};
      r_sr3 <= {r_sr3[0], iInData};
    end
  end

  // Registered window outputs. The window rows load only when a window is
  // emitted, so they hold their value between windows.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      oOutValid   <= 1'b0;
      oFrameDone  <= 1'b0;
      oWindowRow1 <= '0;
      oWindowRow2 <= '0;
      oWindowRow3 <= '0;
    end else if (iSoftClr) begin
      oOutValid   <= 1'b0;
      oFrameDone  <= 1'b0;
    end else begin
      oOutValid   <= iInValid & w_win_ok;
      oFrameDone  <= iInValid & w_col_last & w_row_last;
      if (iInValid && w_win_ok) begin
        oWindowRow1 <= w_win1;
        oWindowRow2 <= w_win2;
        oWindowRow3 <= w_win3;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/window3x3_gen.md
WINDOW3X3_GEN -- requirements
Module: window3x3_gen

Interface
REQ-001 Parameter WI, default 8: pixel width in bits, signed two's complement; must equal the downstream conv3x3 WI.
REQ-002 Parameter IMG_W, default 28: pixels per image row, minimum 3.
REQ-003 Parameter IMG_H, default 28: rows per frame, minimum 3.
REQ-004 iClk  input  1  single clock; all state updates on rising edge.
REQ-005 iRsn  input  1  reset, asynchronous, active-low.
REQ-006 iSoftClr  input  1  synchronous frame restart, active-high.
REQ-007 iInValid  input  1  iInData is a valid pixel this cycle; no backpressure exists.
REQ-008 iInData  input  WI  pixel, raster order: row-major, left to right.
REQ-009 oOutValid  output  1  window outputs are valid this cycle.
REQ-010 oWindowRow1  output  3*WI  top window row (oldest image row).
REQ-011 oWindowRow2  output  3*WI  middle window row.
REQ-012 oWindowRow3  output  3*WI  bottom window row (current image row).
REQ-013 oFrameDone  output  1  one-cycle pulse: last pixel of the frame was accepted.

Function
REQ-014 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) shall advance only on cycles with iInValid=1.
REQ-015 col shall wrap IMG_W-1 -> 0 and increment row; at row=IMG_H-1, col=IMG_W-1 both counters shall wrap to 0.
REQ-016 Two line buffers, each IMG_W x WI, shall hold image rows row-1 and row-2; on each accepted pixel, location col shall shift: lb1[col] -> lb0[col], iInData -> lb1[col].
REQ-017 A 3x3 shift register shall take column {lb0[col], lb1[col], iInData} (pre-update values) on each accepted pixel; older columns shift left.
REQ-018 Window packing: each row vector shall be {left, middle, right}, with the left pixel (column col-2) in bits [3*WI-1:2*WI] and the right pixel (column col) in bits [WI-1:0].
REQ-019 oWindowRow1 shall hold image row row-2, oWindowRow2 row row-1, oWindowRow3 row row.
REQ-020 Valid windows only, no padding: oOutValid shall be 1 exactly one cycle after an accepted pixel with row>=2 and col>=2, and 0 otherwise.
REQ-021 Window count per frame shall be (IMG_W-2)*(IMG_H-2); the default is 676.
REQ-022 Latency shall be 1 cycle from accepting the pixel to the registered window outputs.
REQ-023 Window outputs shall hold their last value while oOutValid=0.
REQ-024 Gaps in iInValid shall not alter content or ordering; the output shall be identical to the same pixel stream delivered without gaps.
REQ-025 Windows shall never span a row boundary; the shift-register columns from the previous row shall be masked by the col>=2 condition.
REQ-026 oFrameDone shall be registered and asserted the cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted, coincident with the final oOutValid.
REQ-027 The next frame shall start seamlessly on the following pixel; stale line-buffer data shall be masked by the row>=2 condition.
REQ-028 iSoftClr=1 shall force col=row=0, oOutValid=0 and oFrameDone=0 next cycle, with priority over iInValid; the pixel presented in that cycle shall be discarded.

Reset
REQ-029 iRsn=0 shall immediately clear col, row, oOutValid, oFrameDone, all window outputs and the 3x3 shift register to 0.
REQ-030 Line-buffer memory need not be reset; the masking in REQ-020 and REQ-027 makes its contents unobservable.
REQ-031 Reset asserted mid-frame shall abandon the frame; the first pixel after release shall be (0,0).

Verification (IMG_W=5, IMG_H=4, WI=8, pixel value = raster index 0..19)
REQ-032 Contiguous frame -> exactly 6 windows. The first follows index 12: Row1={0,1,2}, Row2={5,6,7}, Row3={10,11,12}. The last follows index 19: Row1={7,8,9}, Row2={12,13,14}, Row3={17,18,19}, with oFrameDone=1 on the same cycle.
REQ-033 Same frame with iInValid toggling 1,0,0,1 pattern -> the same 6 windows in the same order; the window outputs hold during gaps.
REQ-034 Indices 0-9 are accepted and never produce oOutValid; index 10 and index 15 (col=0) produce no window.
REQ-035 Two back-to-back frames, the second using values 100+index -> the first window of frame 2 is Row1={100,101,102}, with no frame-1 data visible.
REQ-036 iRsn pulsed low after index 13 -> all outputs are 0 immediately; resending from index 0 gives the REQ-032 result.
REQ-037 iSoftClr asserted with iInValid=1 at index 7 -> that pixel is dropped; the counter restarts, and the stream resent from index 0 gives the REQ-032 result.
